// File: rtl/instr_loader_pkg.sv
// instr_loader_pkg: shared types and sizing for the boot-time instruction loader.
package instr_loader_pkg;
  typedef enum logic [2:0] {LEN, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  localparam int WORD_BYTES = 4;
  localparam int MAX_BYTE_ADDR = 4095;
  localparam int INSTR_MEM_WORDS = (MAX_BYTE_ADDR + 1) / WORD_BYTES;
endpackage

// File: rtl/instr_loader_word_assembler.sv
// word_assembler: collects little-endian bytes into a 32-bit word, flags the completing byte.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);
  localparam int LW = $clog2(WORD_BYTES);
  logic [LW-1:0] lane;
  logic [31:0]   shreg;
  // word is the value including the byte being loaded, so it is complete on word_full
  assign word = {data, shreg[31:8]};
  assign word_full = load && lane == LW'(WORD_BYTES - 1);
  always_ff @(posedge clk_i) begin
    if (clear) begin
      lane  <= '0;
      shreg <= '0;
    end else if (load) begin
      lane  <= lane + LW'(1);
      shreg <= word;
    end
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams a length-prefixed byte frame into instruction memory; optional trailer checksum via LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int MEM_WORDS = INSTR_MEM_WORDS
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        error_o
);
  localparam int IW = $clog2(MEM_WORDS + 1);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
  logic [7:0] sum;
`else
  localparam state_t FIN = DONE;
`endif
  state_t        state;
  logic [IW-1:0] word_idx, len;
  logic [31:0]   word;
  logic          word_full, accept;
  assign rx_ready_o = state == LEN || state == DATA || state == CHECK;
  assign accept     = rx_valid_i && rx_ready_o;
  assign core_rst_o = state != DONE;
  assign done_o     = state == DONE;
  assign error_o    = state == ERROR;
  word_assembler u_asm (
    .clk_i     (clk_i),
    .clear     (rst_i),
    .load      (accept && state != CHECK),
    .data      (rx_data_i),
    .word      (word),
    .word_full (word_full)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= LEN;
      word_idx    <= '0;
      len         <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
`endif
    end else begin
      mem_we_o <= 1'b0;
      case (state)
        LEN:
          if (word_full) begin
            len   <= IW'(word);
            state <= word == '0 ? FIN : word > 32'(MEM_WORDS) ? ERROR : DATA;
          end
        DATA:
          if (accept) begin
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + rx_data_i;
`endif
            if (word_full) begin
              state       <= WRITE;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= 32'(word_idx) << 2;
              mem_wdata_o <= word;
            end
          end
        WRITE: begin
          word_idx <= word_idx + IW'(1);
          state    <= word_idx + IW'(1) == len ? FIN : DATA;
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK:
          if (accept) state <= rx_data_i == sum ? DONE : ERROR;
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized directed bench comparing memory writes against a word-level frame model.
module tb_instr_loader;
  logic        clk = 1'b0, rst_i = 1'b1, rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_ready_o, mem_we_o, core_rst_o, done_o, error_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  int          checks = 0, errors = 0, cyc = 0, ready_bad = 0;
  logic [7:0]  fb[$];
  logic [31:0] fw[$];
  logic [63:0] wq[$];
  int          wcyc[$];

  instr_loader dut (
    .clk_i(clk), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .core_rst_o(core_rst_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (mem_we_o) begin
      wq.push_back({mem_addr_o, mem_wdata_o});
      wcyc.push_back(cyc);
      if (rx_ready_o) ready_bad++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    rx_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    wq.delete();
    wcyc.delete();
    ready_bad = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    rx_data_i = b;
    rx_valid_i = 1'b1;
    while (!rx_ready_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready_o) begin
      checks++;
      errors++;
      $error("FAIL rx_stall: ready stayed 0 for %0d cycles", t);
    end
    @(negedge clk);
    rx_valid_i = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic add_trailer();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] s = '0;
    for (int i = 4; i < fb.size(); i++) s += fb[i];
    fb.push_back(s);
`endif
  endtask

  // frame = little-endian count followed by each expected word, low byte first
  task automatic build(input logic [31:0] n);
    fb.delete();
    for (int k = 0; k < 4; k++) fb.push_back(n[8*k +: 8]);
    foreach (fw[i]) for (int k = 0; k < 4; k++) fb.push_back(fw[i][8*k +: 8]);
    add_trailer();
  endtask

  task automatic send_all(input int maxgap);
    for (int i = 0; i < fb.size(); i++)
      send_byte(fb[i], i == fb.size() - 1 ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

  task automatic check_writes(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_count"}, 32'(wq.size()), 32'(fw.size()));
    for (int i = 0; i < wq.size() && i < fw.size(); i++) begin
      chk({tag, "_addr"}, wq[i][63:32], 32'(i * 4));
      chk({tag, "_data"}, wq[i][31:0], fw[i]);
    end
  endtask

  initial begin
    int bad;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_ready", 32'(rx_ready_o), 1);
    chk("rst_we", 32'(mem_we_o), 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_core_rst", 32'(core_rst_o), 1);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_error", 32'(error_o), 0);

    fw = '{32'h00100513, 32'h00200593};
    fb = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    add_trailer();
    send_all(3);
`ifdef LOADER_CHECKSUM_EN
    chk("a_done", 32'(done_o), 1);
`else
    chk("a_we_last", 32'(mem_we_o), 1);
    chk("a_done_in_write", 32'(done_o), 0);
    @(negedge clk);
    chk("a_done", 32'(done_o), 1);
    chk("a_core_rst", 32'(core_rst_o), 0);
`endif
    check_writes("a");

    do_reset();
    fw.delete();
    build(0);
    send_all(0);
    chk("b_done", 32'(done_o), 1);
    chk("b_core_rst", 32'(core_rst_o), 0);
    check_writes("b");

    do_reset();
    build(1025);
    for (int i = 0; i < 4; i++) send_byte(fb[i], 0);
    chk("c_error", 32'(error_o), 1);
    chk("c_ready", 32'(rx_ready_o), 0);
    chk("c_core_rst", 32'(core_rst_o), 1);
    chk("c_done", 32'(done_o), 0);
    rx_valid_i = 1'b1;
    repeat (5) @(negedge clk);
    rx_valid_i = 1'b0;
    chk("c_ready_held", 32'(rx_ready_o), 0);
    chk("c_error_held", 32'(error_o), 1);
    check_writes("c");

    do_reset();
    for (int i = 0; i < 1024; i++) fw.push_back($urandom());
    build(1024);
    send_all(0);
    check_writes("d");
    bad = 0;
    for (int i = 1; i < wcyc.size(); i++) if (wcyc[i] - wcyc[i-1] != 5) bad++;
    chk("d_spacing", 32'(bad), 0);
    chk("d_ready_in_write", 32'(ready_bad), 0);
    chk("d_done", 32'(done_o), 1);
    chk("d_addr_hold", mem_addr_o, 32'hFFC);
    chk("d_wdata_hold", mem_wdata_o, fw[1023]);

    do_reset();
    fw.delete();
    for (int i = 0; i < 3; i++) fw.push_back($urandom());
    build(3);
    send_all(7);
    check_writes("e");
    chk("e_done", 32'(done_o), 1);

    do_reset();
    fw = '{32'h00100513, 32'h00200593};
    build(2);
    for (int i = 0; i < 6; i++) send_byte(fb[i], 0);
    do_reset();
    chk("f_ready", 32'(rx_ready_o), 1);
    chk("f_core_rst", 32'(core_rst_o), 1);
    chk("f_done", 32'(done_o), 0);
    fw = '{32'hDEADBEEF};
    build(1);
    send_all(2);
    check_writes("f");
    chk("f_done_end", 32'(done_o), 1);

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    fw = '{32'h04030201};
    build(1);
    chk("g_sum", 32'(fb[fb.size()-1]), 32'h0A);
    fb[fb.size()-1] = 8'h0B;
    send_all(1);
    chk("g_error", 32'(error_o), 1);
    chk("g_core_rst", 32'(core_rst_o), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time program loader for the single-cycle RISC-V core. It accepts a byte stream from a UART receiver or debug bridge, assembles little-endian 32-bit words, and writes them sequentially into the instruction memory's write port starting at byte address 0. The core is held in reset until the load completes. The block sits between the serial front end and the instruction memory, and owns that memory's write side at boot.

## Interface
Parameters:
- MEM_WORDS, 1024: instruction memory depth in 32-bit words; maximum accepted program length.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- rx_data_i  in  8  stream byte.
- rx_valid_i  in  1  rx_data_i valid.
- rx_ready_o  out  1  loader accepts byte; transfer when rx_valid_i & rx_ready_o.
- mem_we_o  out  1  instruction memory write strobe, one cycle per word.
- mem_addr_o  out  32  byte address of write, word-aligned (bits [1:0] = 0).
- mem_wdata_o  out  32  word to write.
- core_rst_o  out  1  core reset request, high until load done.
- done_o  out  1  load completed successfully (sticky until rst_i).
- error_o  out  1  load aborted (sticky until rst_i).

## Operation
- Frame format: 4-byte little-endian word count N, then 4*N payload bytes, each word little-endian. With LOADER_CHECKSUM_EN, one trailer byte follows.
- States: LEN (collect 4 length bytes), DATA (collect 4 payload bytes), WRITE (issue one memory write), CHECK (checksum only), DONE, ERROR.
- LEN: after the 4th byte, compare the full 32-bit N.
  - N == 0 goes to DONE (or CHECK).
  - N > MEM_WORDS goes to ERROR.
  - Otherwise go to DATA.
- DATA: byte k of a word lands in bits [8k+7:8k]. The 4th byte moves the FSM to WRITE.
- WRITE: drives mem_we_o=1, mem_addr_o = word_idx*4, mem_wdata_o = assembled word. It then increments word_idx.
  - If word_idx+1 == N, go to DONE (or CHECK).
  - Otherwise return to DATA.
- DONE and ERROR are terminal. Only rst_i leaves them. Further bytes are ignored because rx_ready_o is 0.
- rx_ready_o = 1 in LEN, DATA and CHECK; 0 in WRITE, DONE and ERROR. It is combinational from the state register only and never depends on rx_valid_i.
- core_rst_o = 1 in every state except DONE. done_o = (state == DONE). error_o = (state == ERROR).
- word_idx width is $clog2(MEM_WORDS+1). The byte-lane counter is 2 bits and wraps 3→0 on each completed word.

## Timing
- Reset values: state LEN, word_idx 0, byte lane 0, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0, core_rst_o 1, done_o 0, error_o 0, rx_ready_o 1.
- Acceptance latency: the 4th byte of a word is accepted in cycle t, and mem_we_o is high in cycle t+1, for exactly one cycle.
- Minimum spacing: 5 cycles per word (4 accepts plus 1 WRITE). A byte offered during WRITE is stalled, not dropped.
- After the last WRITE (cycle t), DONE is entered at t+1. From t+1, core_rst_o=0 and done_o=1.
- ERROR is entered the cycle after the 4th length byte is accepted.
- mem_addr_o and mem_wdata_o are registered. They hold their last values outside WRITE; only mem_we_o qualifies them.
- rx_valid_i gaps of any length are tolerated with no state change.
- rst_i asserted mid-load, in any state, takes effect at the next edge: FSM to LEN, counters cleared, partial word discarded, core_rst_o=1. Memory contents already written are not cleared.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The loader keeps an 8-bit modulo-256 sum of all payload bytes.
  - After the final WRITE (or after the length field when N=0), it enters CHECK and accepts one trailer byte.
  - If the byte equals the sum, go to DONE; otherwise go to ERROR.
- LOADER_CHECKSUM_EN undefined: CHECK state and sum register are absent. Transitions go straight to DONE.

## Structure
- Package instr_loader_pkg holds:
  - the state enum typedef (LEN, DATA, WRITE, CHECK, DONE, ERROR);
  - WORD_BYTES = 4;
  - INSTR_MEM_WORDS = 1024, shared with the instruction memory;
  - the max byte address 4095.
- One sub-module, word_assembler, holds the 2-bit lane counter and 32-bit shift/insert register. It exposes load/clear/word_full and is reused for both the length field and payload words.

## Test plan
- Length 02 00 00 00, payload 13 05 10 00 93 05 20 00 -> two writes: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593. Then done_o=1 and core_rst_o=0 the cycle after the 2nd write.
- Length 00 00 00 00 -> no mem_we_o pulse; done_o=1 one cycle after the 4th byte (without checksum).
- Length 01 04 00 00 (1025) -> error_o=1, rx_ready_o=0, core_rst_o stays 1, no writes. Length 00 04 00 00 (1024) -> accepted, last write at addr 0xFFC.
- rx_valid_i held high continuously -> rx_ready_o drops in every WRITE cycle, no byte lost, 5 cycles per word. Random valid gaps -> identical written data.
- rst_i pulsed after 6 bytes of a 2-word load, then a full 1-word frame (payload EF BE AD DE) -> single write addr 0x0 data 0xDEADBEEF, done_o=1.
- With LOADER_CHECKSUM_EN: a 1-word frame with payload 01 02 03 04 and trailer 0x0A ends in done_o=1. The same frame with trailer 0x0B ends in error_o=1 and core_rst_o=1.
